// File: rtl/usb1bd_rx_pkt_buf_pkg.sv
// Shared types and sizing for the USB1 device receive packet buffer.
// Pointer widths carry one extra wrap bit above the address.
package usb1bd_pkg;

  localparam int USB1BD_AW    = 6;
  localparam int USB1BD_LQ_AW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/usb1bd_rx_pkt_buf_if.sv
// Decoder-facing and consumer-facing signal bundle of the RX packet buffer.
// master drives stimulus/consumption, slave is the buffer itself.
interface usb1bd_rx_pkt_buf_if #(
  parameter int AW    = 6,
  parameter int LQ_AW = 2
);

  logic [7:0]    rx_fifo_data;
  logic          rx_fifo_dvalid;
  logic          rx_fifo_ddone;
  logic          crc16_err;
  logic          flush;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_empty;
  logic          pkt_avail;
  logic [AW:0]   pkt_len;
  logic          pkt_pop;
  logic [LQ_AW:0] pkt_cnt;
  logic          drop_crc;
  logic          drop_ovf;

  modport master (
    output rx_fifo_data, rx_fifo_dvalid, rx_fifo_ddone,
    output crc16_err, flush, rd_en, pkt_pop,
    input  rd_data, rd_empty, pkt_avail, pkt_len,
    input  pkt_cnt, drop_crc, drop_ovf
  );

  modport slave (
    input  rx_fifo_data, rx_fifo_dvalid, rx_fifo_ddone,
    input  crc16_err, flush, rd_en, pkt_pop,
    output rd_data, rd_empty, pkt_avail, pkt_len,
    output pkt_cnt, drop_crc, drop_ovf
  );

endinterface

// File: rtl/usb1bd_rx_pkt_buf_len_q.sv
// Length queue: small synchronous FIFO of committed packet byte counts.
// Head reads as zero while empty so pkt_len is well defined.
module usb1bd_len_q #(
  parameter int W  = 7,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [AW:0]  o_cnt,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_cnt     = r_wp - r_rp;
  assign o_full    = (o_cnt == FULL_CNT);
  assign o_empty   = (r_wp == r_rp);
  assign o_head    = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + ONE;
      if (w_pop_ok)  r_rp <= r_rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr)
      r_mem[r_wp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/usb1bd_rx_pkt_buf.sv
// Packet-granular RX buffer: speculative writes, commit on good CRC,
// rollback on CRC error or overflow, byte stream plus length queue out.
import usb1bd_pkg::*;

module usb1bd_rx_pkt_buf #(
  parameter int AW    = USB1BD_AW,
  parameter int LQ_AW = USB1BD_LQ_AW
) (
  input logic clk,
  input logic rst,
  usb1bd_rx_pkt_buf_if.slave bus
);

  localparam int PW    = ptr_w(AW);
  localparam int DEPTH = 1 << AW;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t ONE       = ptr_t'(1);
  localparam ptr_t FULL_DIST = ptr_t'(DEPTH);

  logic [7:0] r_mem [DEPTH];

  ptr_t       r_wr_spec;
  ptr_t       r_wr_cmt;
  ptr_t       r_rd_ptr;
  ptr_t       r_cur_len;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_rd_data;
  logic       r_drop_crc;
  logic       r_drop_ovf;

  logic       w_clr;
  logic       w_full;
  logic       w_rd_empty;
  logic       w_rd_acc;
  logic       w_wr_en;
  logic       w_ovf_now;
  logic       w_commit;
  logic       w_drop_crc;
  logic       w_drop_ovf;
  ptr_t       w_len_in;
  ptr_t       w_lq_head;
  logic [LQ_AW:0] w_lq_cnt;
  logic       w_lq_full;
  logic       w_lq_empty;
  logic       w_pop;

  assign w_clr      = rst | bus.flush;
  assign w_full     = ((r_wr_spec - r_rd_ptr) == FULL_DIST);
  assign w_rd_empty = (r_wr_cmt == r_rd_ptr);
  assign w_rd_acc   = bus.rd_en & ~w_rd_empty;
  assign w_len_in   = r_cur_len + ptr_t'(w_wr_en);
  assign w_pop      = bus.pkt_pop & ~w_lq_empty;

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.rx_fifo_ddone)
          w_state_nxt = IDLE;
        else if (bus.rx_fifo_dvalid && w_full)
          w_state_nxt = DROP;
        else if (bus.rx_fifo_dvalid)
          w_state_nxt = RECV;
      end
      RECV: begin
        if (bus.rx_fifo_ddone)
          w_state_nxt = IDLE;
        else if (bus.rx_fifo_dvalid && w_full)
          w_state_nxt = DROP;
      end
      DROP: begin
        if (bus.rx_fifo_ddone)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // An overflowing byte in the ddone cycle spoils the packet as a whole.
  always_comb begin
    w_wr_en    = bus.rx_fifo_dvalid & ~w_full & (r_state != DROP);
    w_ovf_now  = bus.rx_fifo_dvalid &  w_full & (r_state != DROP);
    w_commit   = 1'b0;
    w_drop_crc = 1'b0;
    w_drop_ovf = 1'b0;
    if (bus.rx_fifo_ddone) begin
      if (r_state == DROP || w_ovf_now)
        w_drop_ovf = 1'b1;
      else if (bus.crc16_err)
        w_drop_crc = 1'b1;
      else if (w_lq_full)
        w_drop_ovf = 1'b1;
      else
        w_commit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_spec  <= '0;
      r_wr_cmt   <= '0;
      r_rd_ptr   <= '0;
      r_cur_len  <= '0;
      r_rd_data  <= '0;
      r_drop_crc <= 1'b0;
      r_drop_ovf <= 1'b0;
    end else begin
      r_drop_crc <= w_drop_crc;
      r_drop_ovf <= w_drop_ovf;
      if (w_wr_en)
        r_wr_spec <= r_wr_spec + ONE;
      if (w_drop_crc || w_drop_ovf)
        r_wr_spec <= r_wr_cmt;
      if (w_commit)
        r_wr_cmt <= r_wr_spec + ptr_t'(w_wr_en);
      if (bus.rx_fifo_ddone)
        r_cur_len <= '0;
      else if (w_wr_en)
        r_cur_len <= r_cur_len + ONE;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !w_clr)
      r_mem[r_wr_spec[AW-1:0]] <= bus.rx_fifo_data;
  end

  usb1bd_len_q #(
    .W  (PW),
    .AW (LQ_AW)
  ) u_len_q (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_push  (w_commit),
    .i_data  (w_len_in),
    .i_pop   (w_pop),
    .o_head  (w_lq_head),
    .o_cnt   (w_lq_cnt),
    .o_full  (w_lq_full),
    .o_empty (w_lq_empty)
  );

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_empty  = w_rd_empty;
  assign bus.pkt_avail = ~w_lq_empty;
  assign bus.pkt_len   = w_lq_head;
  assign bus.pkt_cnt   = w_lq_cnt;
  assign bus.drop_crc  = r_drop_crc;
  assign bus.drop_ovf  = r_drop_ovf;

endmodule

// File: tb/tb_usb1bd_rx_pkt_buf.sv
// Directed bench for usb1bd_rx_pkt_buf: commit, rollback, overflow,
// length-queue limits, zero-length packets, flush and reset.
module tb_usb1bd_rx_pkt_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  usb1bd_rx_pkt_buf_if #(.AW(6), .LQ_AW(2)) bus ();

  usb1bd_rx_pkt_buf #(.AW(6), .LQ_AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_fifo_dvalid = 1'b1;
    bus.rx_fifo_data   = b;
    tick();
    bus.rx_fifo_dvalid = 1'b0;
  endtask

  task automatic done(input logic err);
    bus.rx_fifo_ddone = 1'b1;
    bus.crc16_err     = err;
    tick();
    bus.rx_fifo_ddone = 1'b0;
    bus.crc16_err     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic pop();
    bus.pkt_pop = 1'b1;
    tick();
    bus.pkt_pop = 1'b0;
  endtask

  initial begin
    bus.rx_fifo_data   = '0;
    bus.rx_fifo_dvalid = 1'b0;
    bus.rx_fifo_ddone  = 1'b0;
    bus.crc16_err      = 1'b0;
    bus.flush          = 1'b0;
    bus.rd_en          = 1'b0;
    bus.pkt_pop        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_empty", 32'(bus.rd_empty), 1);
    chk("rst_avail", 32'(bus.pkt_avail), 0);
    chk("rst_len", 32'(bus.pkt_len), 0);
    chk("rst_cnt", 32'(bus.pkt_cnt), 0);
    chk("rst_dcrc", 32'(bus.drop_crc), 0);
    chk("rst_dovf", 32'(bus.drop_ovf), 0);
    chk("rst_rdata", 32'(bus.rd_data), 0);

    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    chk("spec_hidden", 32'(bus.rd_empty), 1);
    done(1'b0);
    chk("good_avail", 32'(bus.pkt_avail), 1);
    chk("good_len", 32'(bus.pkt_len), 3);
    chk("good_cnt", 32'(bus.pkt_cnt), 1);
    chk("good_nempty", 32'(bus.rd_empty), 0);
    rd("good_b0", 8'hA1);
    rd("good_b1", 8'hB2);
    rd("good_b2", 8'hC3);
    chk("good_drained", 32'(bus.rd_empty), 1);
    pop();
    chk("good_popped", 32'(bus.pkt_avail), 0);
    chk("good_cnt0", 32'(bus.pkt_cnt), 0);

    for (int i = 1; i <= 5; i++) send(8'(i));
    done(1'b1);
    chk("crc_pulse", 32'(bus.drop_crc), 1);
    chk("crc_novf", 32'(bus.drop_ovf), 0);
    chk("crc_empty", 32'(bus.rd_empty), 1);
    chk("crc_cnt", 32'(bus.pkt_cnt), 0);
    tick();
    chk("crc_pulse_end", 32'(bus.drop_crc), 0);
    send(8'h11);
    send(8'h22);
    done(1'b0);
    chk("crc2_len", 32'(bus.pkt_len), 2);
    rd("crc2_b0", 8'h11);
    rd("crc2_b1", 8'h22);
    pop();

    for (int i = 0; i < 65; i++) send(8'(i));
    chk("ovf_hidden", 32'(bus.rd_empty), 1);
    done(1'b0);
    chk("ovf_pulse", 32'(bus.drop_ovf), 1);
    chk("ovf_empty", 32'(bus.rd_empty), 1);
    chk("ovf_cnt", 32'(bus.pkt_cnt), 0);
    for (int i = 0; i < 64; i++) send(8'(i) + 8'h40);
    done(1'b0);
    chk("max_len", 32'(bus.pkt_len), 64);
    chk("max_cnt", 32'(bus.pkt_cnt), 1);
    chk("max_nopulse", 32'(bus.drop_ovf), 0);
    bus.rx_fifo_dvalid = 1'b1;
    bus.rx_fifo_data   = 8'hEE;
    bus.rd_en          = 1'b1;
    tick();
    bus.rx_fifo_dvalid = 1'b0;
    bus.rd_en          = 1'b0;
    chk("full_rw_b0", 32'(bus.rd_data), 32'h40);
    done(1'b0);
    chk("full_rw_ovf", 32'(bus.drop_ovf), 1);
    chk("full_rw_cnt", 32'(bus.pkt_cnt), 1);
    for (int i = 1; i < 64; i++) rd("max_byte", 8'(i) + 8'h40);
    chk("max_drained", 32'(bus.rd_empty), 1);
    pop();

    for (int k = 0; k < 5; k++) begin
      send(8'h30 + 8'(k));
      done(1'b0);
      if (k == 3) chk("lq_cnt4", 32'(bus.pkt_cnt), 4);
    end
    chk("lq_ovf", 32'(bus.drop_ovf), 1);
    chk("lq_cnt_held", 32'(bus.pkt_cnt), 4);
    for (int k = 0; k < 4; k++) rd("lq_byte", 8'h30 + 8'(k));
    chk("lq_5th_gone", 32'(bus.rd_empty), 1);
    for (int k = 0; k < 4; k++) begin
      chk("lq_len1", 32'(bus.pkt_len), 1);
      pop();
    end
    chk("lq_cnt0", 32'(bus.pkt_cnt), 0);

    done(1'b0);
    chk("zl_avail", 32'(bus.pkt_avail), 1);
    chk("zl_len", 32'(bus.pkt_len), 0);
    chk("zl_empty", 32'(bus.rd_empty), 1);
    pop();
    send(8'h77);
    bus.rx_fifo_dvalid = 1'b1;
    bus.rx_fifo_data   = 8'h88;
    done(1'b0);
    bus.rx_fifo_dvalid = 1'b0;
    chk("same_len", 32'(bus.pkt_len), 2);
    chk("same_cnt", 32'(bus.pkt_cnt), 1);
    rd("same_b0", 8'h77);
    rd("same_b1", 8'h88);
    pop();

    send(8'h99);
    done(1'b0);
    chk("pre_flush_cnt", 32'(bus.pkt_cnt), 1);
    for (int i = 0; i < 10; i++) send(8'hD0 + 8'(i));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_empty", 32'(bus.rd_empty), 1);
    chk("flush_cnt", 32'(bus.pkt_cnt), 0);
    chk("flush_avail", 32'(bus.pkt_avail), 0);
    chk("flush_rdata", 32'(bus.rd_data), 0);
    done(1'b0);
    chk("flush_zl_cnt", 32'(bus.pkt_cnt), 1);
    chk("flush_zl_len", 32'(bus.pkt_len), 0);
    chk("flush_zl_empty", 32'(bus.rd_empty), 1);

    for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cnt", 32'(bus.pkt_cnt), 0);
    chk("rst2_empty", 32'(bus.rd_empty), 1);
    done(1'b0);
    chk("rst2_zl_cnt", 32'(bus.pkt_cnt), 1);
    chk("rst2_zl_len", 32'(bus.pkt_len), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
